// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op encodings,
// depth limit and the combinational operation itself.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_ANDN   = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

  localparam int MAX_STAGES = 4;
  localparam int MAX_WIDTH  = 64;

  // Evaluated at full width; callers size-cast the result down to their operand width.
  function automatic logic [MAX_WIDTH-1:0] logic_op(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input op_e                  op
  );
    logic [MAX_WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_ANDN: r = a & ~b;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipelined_logic_unit_if.sv
// Operand/result handshake bundle between producers, the logic unit and its consumer.
interface pipelined_logic_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_ones;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_ones
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_ones
  );
endinterface

// File: rtl/logic_pipe_stage.sv
// One valid/payload register slice; a load wins over an advance so a
// simultaneous drain-and-refill keeps the stage full with the new payload.
module logic_pipe_stage #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_adv,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_adv) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipelined_logic_unit.sv
// Registered bitwise logic unit: stage 0 captures result plus zero/ones flags,
// later stages only delay them; stalls ripple back combinationally.
module pipelined_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipelined_logic_unit_if.slave  bus
);

  localparam int PW = WIDTH + 2;

  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_load;
  logic [PW-1:0]     w_stage_in [STAGES];
  logic [PW-1:0]     w_data     [STAGES];
  logic [WIDTH-1:0]  w_res;
  logic              w_zero;
  logic              w_ones;
  logic              w_in_ready;

  if (STAGES < 1 || STAGES > MAX_STAGES || WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_param_err
    $error("pipelined_logic_unit: WIDTH must be 1..64 and STAGES 1..%0d", MAX_STAGES);
  end

  assign w_res      = WIDTH'(logic_op(MAX_WIDTH'(bus.in_a), MAX_WIDTH'(bus.in_b), op_e'(bus.in_op)));
  assign w_zero     = (w_res == '0);
  assign w_ones     = &w_res;
  assign w_in_ready = !w_valid[0] || w_adv[0];

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == STAGES - 1) begin : g_last
      assign w_adv[gi] = w_valid[gi] && bus.out_ready;
    end else begin : g_mid
      assign w_adv[gi] = w_valid[gi] && (!w_valid[gi+1] || w_adv[gi+1]);
    end

    if (gi == 0) begin : g_head
      assign w_load[gi]     = bus.in_valid && w_in_ready;
      assign w_stage_in[gi] = {w_ones, w_zero, w_res};
    end else begin : g_tail
      assign w_load[gi]     = w_adv[gi-1];
      assign w_stage_in[gi] = w_data[gi-1];
    end

    logic_pipe_stage #(
      .W (PW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[gi]),
      .i_adv   (w_adv[gi]),
      .i_data  (w_stage_in[gi]),
      .o_valid (w_valid[gi]),
      .o_data  (w_data[gi])
    );
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid[STAGES-1];
  assign {bus.out_ones, bus.out_zero, bus.out_data} = w_data[STAGES-1];

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// Bench for pipelined_logic_unit (WIDTH=8, STAGES=2): vector table, hand-built
// streaming/backpressure/reset sequences and a random run against a LUT model.
module tb_pipelined_logic_unit;
  import logic_unit_pkg::*;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  typedef struct {
    logic [7:0] data;
    logic       zero;
    logic       ones;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] d;
    logic       z;
    logic       o;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_logic_unit_if #(.WIDTH(WIDTH)) bus();

  pipelined_logic_unit #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  res_t exp_q[$];
  logic hold_pending = 1'b0;
  res_t held;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each op is a 2-input truth table indexed by {a_bit, b_bit}.
  function automatic res_t ref_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [3:0] lut [8];
    logic [3:0] sel;
    res_t r;
    lut = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0100, 4'b1100};
    sel = lut[op];
    for (int i = 0; i < 8; i++) r.data[i] = sel[{a[i], b[i]}];
    r.zero = (r.data == 8'h00);
    r.ones = (r.data == 8'hFF);
    return r;
  endfunction

  // One clock: scoreboard at the falling edge, then return 1 time unit after the rising edge.
  task automatic step();
    res_t e;
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_payload", {bus.out_ones, bus.out_zero, bus.out_data}, {held.ones, held.zero, held.data});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got %0h expected no result at %0t", bus.out_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", 64'(bus.out_data), 64'(e.data));
          chk("sb_zero", 64'(bus.out_zero), 64'(e.zero));
          chk("sb_ones", 64'(bus.out_ones), 64'(e.ones));
        end
      end
      hold_pending = bus.out_valid && !bus.out_ready;
      held.data = bus.out_data;
      held.zero = bus.out_zero;
      held.ones = bus.out_ones;
      if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_op(bus.in_a, bus.in_b, bus.in_op));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input logic v);
    bus.in_valid = v;
    bus.in_a     = 8'($urandom);
    bus.in_b     = 8'($urandom);
    bus.in_op    = 3'($urandom);
  endtask

  initial begin
    int         acc;
    int         cnt;
    logic [9:0] snap;

    vecs[0] = '{8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'hFF, 3'd3, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hAA, 8'hAA, 3'd5, 8'hFF, 1'b0, 1'b1};
    vecs[3] = '{8'hF0, 8'h30, 3'd6, 8'hC0, 1'b0, 1'b0};
    vecs[4] = '{8'h5A, 8'hC3, 3'd7, 8'h5A, 1'b0, 1'b0};
    vecs[5] = '{8'h0F, 8'hF0, 3'd1, 8'hFF, 1'b0, 1'b1};
    vecs[6] = '{8'h3C, 8'h3C, 3'd2, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h0F, 8'h30, 3'd4, 8'hC0, 1'b0, 1'b0};

    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    drive_rand(1'b1);
    step();
    step();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_out_zero",  64'(bus.out_zero),  64'd0);
    chk("rst_out_ones",  64'(bus.out_ones),  64'd0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    step();

    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = vecs[i].a;
      bus.in_b     = vecs[i].b;
      bus.in_op    = vecs[i].op;
      step();
      bus.in_valid = 1'b0;
      chk("vec_early_valid", 64'(bus.out_valid), 64'd0);
      step();
      chk("vec_valid", 64'(bus.out_valid), 64'd1);
      chk("vec_data",  64'(bus.out_data),  64'(vecs[i].d));
      chk("vec_zero",  64'(bus.out_zero),  64'(vecs[i].z));
      chk("vec_ones",  64'(bus.out_ones),  64'(vecs[i].o));
      step();
    end

    for (int j = 0; j < 10; j++) begin
      if (j < 8) drive_rand(1'b1);
      else bus.in_valid = 1'b0;
      #1;
      if (j < 8) chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
      step();
      chk("stream_out_valid", 64'(bus.out_valid), 64'(j >= 1 && j <= 8));
    end

    bus.out_ready = 1'b0;
    acc  = 0;
    snap = '0;
    for (int j = 0; j < 4; j++) begin
      drive_rand(1'b1);
      #1;
      if (bus.in_ready) acc++;
      step();
      if (j == 1) snap = {bus.out_ones, bus.out_zero, bus.out_data};
      if (j >= 2) chk("bp_stable", {bus.out_ones, bus.out_zero, bus.out_data}, 64'(snap));
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    drive_rand(1'b1);
    #1;
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk("drain1_valid", 64'(bus.out_valid), 64'd1);
    step();
    chk("drain2_valid", 64'(bus.out_valid), 64'd1);
    step();
    chk("drain_empty", 64'(bus.out_valid), 64'd0);

    drive_rand(1'b1);
    step();
    drive_rand(1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("mr_loaded", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    step();
    chk("mr_cleared", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("mr_no_result", 64'(bus.out_valid), 64'd0);
    end

    for (int j = 0; j < 400; j++) begin
      drive_rand(1'($urandom_range(0, 1)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 20) begin
      step();
      cnt++;
    end
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_out_valid", 64'(bus.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_logic_unit.md
# pipelined_logic_unit

Parametrised, registered bitwise logic unit and the successor to the single-bit registered AND gate. It applies one of eight two-operand bitwise operations, selected per transaction, to WIDTH-bit operands. Results pass through a STAGES-deep valid/ready pipeline with full throughput and backpressure, and each result carries zero and all-ones flags. It sits between operand producers and any downstream consumer that may stall.

## Interface
- WIDTH, default 8: operand/result width, 1..64.
- STAGES, default 2: pipeline depth, which is also the latency in cycles, 1..4.
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: synchronous, active-low reset.
- in_valid  input  1: operand transaction offered.
- in_ready  output  1: unit can accept this cycle.
- in_a  input  WIDTH: operand A.
- in_b  input  WIDTH: operand B.
- in_op  input  3: operation select, encoded per logic_unit_pkg.
- out_valid  output  1: result available.
- out_ready  input  1: consumer accepts the result this cycle.
- out_data  output  WIDTH: result.
- out_zero  output  1: out_data == 0.
- out_ones  output  1: out_data == all ones.

## Operation
- Op encoding:
  - 0 AND
  - 1 OR
  - 2 XOR
  - 3 NAND
  - 4 NOR
  - 5 XNOR
  - 6 ANDN (A & ~B)
  - 7 PASS_A
- Accept: a transfer occurs when in_valid && in_ready at a rising edge. in_a, in_b and in_op are sampled only at that edge.
- Stage 0 registers the computed result and both flags. Stages 1..STAGES-1 only delay the value plus its valid bit.
- Flags are computed from the stage-0 result and travel with it. out_zero and out_ones are never both 1 unless WIDTH==0, which is illegal.
- Each stage k holds a valid bit v[k].
  - Last stage: adv[last] = v[last] && out_ready.
  - Stage k < last: adv[k] = v[k] && (!v[k+1] || adv[k+1]).
- in_ready = !v[0] || adv[0]. in_ready is combinational from the pipeline state and out_ready, with no dependence on in_valid.
- A stage loads when the upstream stage advances. It clears its valid bit when it advances without a reload. Simultaneous advance and reload keeps valid=1 with the new data.
- out_valid = v[last]. out_data and the flags come from the last stage registers.
- Capacity is STAGES transactions. Results leave in strict acceptance order with no drops and no duplicates.
- Output holds: while out_valid && !out_ready, out_data and both flags are stable.
- Reset: when rst_n==0 at an edge, all v[k], data and flags go to 0. In-flight transactions are discarded. Inputs are ignored during that cycle.
- Reset values: out_valid=0, out_data=0, out_zero=0, out_ones=0. in_ready reads 1 on the first cycle after reset.
- in_op values outside the list cannot occur because the field is 3-bit and all codes are defined.

## Timing
- Latency: a transaction accepted at edge N appears with out_valid=1 after edge N+STAGES, if there are no stalls.
- Throughput: 1 result per cycle while out_ready=1.
- Stall propagation is combinational through the adv chain. There are no bubbles on release of a full pipeline.
- Reset takes effect at the first edge with rst_n==0. No asynchronous path exists.

## Structure
- Package logic_unit_pkg holds:
  - op_e enum (3-bit) with the encodings above.
  - MAX_STAGES=4.
  - A function logic_op(a, b, op) returning the WIDTH-bit result, parametrised through a type or width argument.
- Sub-module logic_pipe_stage:
  - One valid/data register slice with load/advance logic, parametrised by payload width (WIDTH+2).
  - Instantiated STAGES times via generate.
- Elaboration-time assertion: 1 <= STAGES <= MAX_STAGES and 1 <= WIDTH <= 64.

## Test plan
All scenarios use WIDTH=8, STAGES=2.
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, out_data=0x00, flags 0, in_ready=1 after release.
- Single AND: a=0xF0, b=0x3C, op=0, accepted at edge N → after edge N+2 out_valid=1, out_data=0x30, out_zero=0, out_ones=0.
- Op sweep with flags:
  - NAND 0xFF,0xFF → 0x00, out_zero=1.
  - XNOR 0xAA,0xAA → 0xFF, out_ones=1.
  - ANDN 0xF0,0x30 → 0xC0.
  - PASS_A 0x5A,x → 0x5A.
- Streaming: 8 back-to-back ops with out_ready=1 → in_ready stays 1 and 8 consecutive results in order, first result at cycle+2.
- Backpressure:
  - Stream with out_ready=0 → exactly 2 accepted, then in_ready=0, and out_data stays stable.
  - Raise out_ready → results drain in order with no bubble, and in_ready rises in the same cycle.
- Reset mid-flight: 2 transactions in pipe, rst_n=0 for one edge → out_valid=0 next cycle, and neither result ever appears.
